// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared branch codes, FSM states and execute-register control bundle.
package branch_resolve_pkg;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic {RUN, SQUASH} state_t;
    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [2:0] funct3;
    } ectl_t;
endpackage

// File: rtl/branch_resolve_cmp.sv
// branch_cmp: evaluates a B-type condition on forwarded operands and flags reserved codes.
module branch_cmp
    import branch_resolve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            cond,
    output logic            illegal
);
    logic eq, lt, ltu;
    always_comb begin
        eq      = src_a == src_b;
        lt      = $signed(src_a) < $signed(src_b);
        ltu     = src_a < src_b;
        cond    = funct3 == F3_BEQ  ? eq   :
                  funct3 == F3_BNE  ? !eq  :
                  funct3 == F3_BLT  ? lt   :
                  funct3 == F3_BGE  ? !lt  :
                  funct3 == F3_BLTU ? ltu  :
                  funct3 == F3_BGEU ? !ltu : 1'b0;
        illegal = funct3[2:1] == 2'b01;
    end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch/jump resolver driving fetch redirects, wrong-path flushes
// and control-flow statistics for a static not-taken fetch.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidD,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             JalrD,
    input  logic [2:0]       Funct3D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  SrcAE,
    input  logic [XLEN-1:0]  SrcBE,
    input  logic             StallE,
    output logic             PCSrcE,
    output logic [XLEN-1:0]  PCTargetE,
    output logic             is_jalrE,
    output logic [XLEN-1:0]  jalr_targetE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             misalignE,
    output logic             illegal_brE,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] jump_cnt
);
    ectl_t           e;
    logic [XLEN-1:0] pc_e, imm_e;
    state_t          state, state_nx;
    logic            cond, illegal, resolve, redirect;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (e.funct3),
        .src_a  (SrcAE),
        .src_b  (SrcBE),
        .cond   (cond),
        .illegal(illegal)
    );

    // SQUASH only ever sees the flushed bubble; gating on RUN is a belt-and-braces guard.
    always_comb begin
        resolve      = e.valid & ~StallE & (state == RUN);
        PCSrcE       = resolve & ((e.branch & cond) | e.jump);
        is_jalrE     = resolve & e.jalr;
        redirect     = PCSrcE | is_jalrE;
        FlushD       = redirect;
        FlushE       = redirect;
        PCTargetE    = pc_e + imm_e;
        jalr_targetE = (SrcAE + imm_e) & {{(XLEN-1){1'b1}}, 1'b0};
        misalignE    = (PCSrcE & PCTargetE[1]) | (is_jalrE & jalr_targetE[1]);
        illegal_brE  = e.valid & e.branch & illegal;
        state_nx     = (state == RUN && redirect) ? SQUASH : RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            e          <= '0;
            pc_e       <= '0;
            imm_e      <= '0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
            jump_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (FlushE) begin
                e     <= '0;
                pc_e  <= '0;
                imm_e <= '0;
            end else if (!StallE) begin
                e     <= '{ValidD, BranchD, JumpD, JalrD, Funct3D};
                pc_e  <= PCD;
                imm_e <= ImmExtD;
            end
            if (resolve & e.branch) branch_cnt <= branch_cnt + CNT_W'(1);
            if (resolve & e.branch & cond) taken_cnt <= taken_cnt + CNT_W'(1);
            if (resolve & (e.jump | e.jalr)) jump_cnt <= jump_cnt + CNT_W'(1);
        end
    end
endmodule
